// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with trap handling.
// Outputs are decoded from the registered state and the captured opcode.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        fetch_valid_i,
  input  logic        mem_ready_i,
  input  logic        branch_taken_i,
  input  logic        trap_clear_i,
  output logic        fetch_req_o,
  output logic        ir_write_o,
  output logic [4:0]  imm_op_o,
  output logic        alu_en_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        reg_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MEM_TO  = 2'b10;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;

  logic [4:0]  op;
  logic        legal;
  logic        is_load, is_store, is_branch, is_jump;

  // funct3 is captured for downstream decoders; the remaining instruction bits are not needed here.
  logic        unused_bits;
  assign unused_bits = ^{instr_i[31:15], instr_i[11:7], funct3_q};

  assign op        = opcode_q[6:2];
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BRANCH);
  assign is_jump   = (op == OP_JAL) || (op == OP_JALR);

  always_comb begin
    legal = 1'b0;
    if (opcode_q[1:0] == 2'b11) begin
      case (op)
        OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
        default:                           legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= '0;
      funct3_q <= '0;
      cnt_q    <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    funct3_d    = funct3_q;
    cnt_d       = cnt_q;
    cause_d     = cause_q;
    fetch_req_o = 1'b0;
    ir_write_o  = 1'b0;
    alu_en_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    reg_write_o = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 1'b0;
    trap_o      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        fetch_req_o = 1'b1;
        if (fetch_valid_i) begin
          opcode_d   = instr_i[6:0];
          funct3_d   = instr_i[14:12];
          ir_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        if (legal) begin
          state_d = S_EXECUTE;
        end else begin
          cause_d = CAUSE_ILLEGAL;
          state_d = S_TRAP;
        end
      end

      S_EXECUTE: begin
        alu_en_o = 1'b1;
        if (is_branch) begin
          pc_write_o = 1'b1;
          pc_src_o   = branch_taken_i;
          state_d    = S_FETCH;
        end else if (is_load || is_store) begin
          cnt_d   = '0;
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end

      S_MEMORY: begin
        mem_req_o = 1'b1;
        mem_we_o  = is_store;
        // A ready on the limit cycle still completes the access normally.
        if (mem_ready_i) begin
          if (is_store) begin
            pc_write_o = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_LIM) begin
            cause_d = CAUSE_MEM_TO;
            state_d = S_TRAP;
          end
        end
      end

      S_WRITEBACK: begin
        reg_write_o = 1'b1;
        pc_write_o  = 1'b1;
        pc_src_o    = is_jump;
        state_d     = S_FETCH;
      end

      S_TRAP: begin
        trap_o = 1'b1;
        if (trap_clear_i) begin
          cause_d = CAUSE_NONE;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign imm_op_o     = opcode_q[6:2];
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: instruction-level model expands each instruction into its expected
// per-cycle output trace; table vectors, hand-written corner cases and random instructions.
module tb_multicycle_control_fsm;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_i = '0;
  logic        fetch_valid_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic        trap_clear_i = 1'b0;
  logic        fetch_req_o, ir_write_o, alu_en_o, mem_req_o, mem_we_o;
  logic        reg_write_o, pc_write_o, pc_src_o, trap_o;
  logic [4:0]  imm_op_o;
  logic [1:0]  trap_cause_o;

  multicycle_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .fetch_valid_i(fetch_valid_i),
    .mem_ready_i(mem_ready_i), .branch_taken_i(branch_taken_i), .trap_clear_i(trap_clear_i),
    .fetch_req_o(fetch_req_o), .ir_write_o(ir_write_o), .imm_op_o(imm_op_o),
    .alu_en_o(alu_en_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .reg_write_o(reg_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       fetch_req;
    logic       ir_write;
    logic [4:0] imm_op;
    logic       alu_en;
    logic       mem_req;
    logic       mem_we;
    logic       reg_write;
    logic       pc_write;
    logic       pc_src;
    logic       trap;
    logic [1:0] trap_cause;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic        bt;
    int          mwait;
    int          lat;
    logic [4:0]  imm;
    bit          rw;
  } vec_t;

  out_t       act;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         fetch_cyc = 1 << 30;
  int         ret_cyc = 0;
  bit         ret_seen = 0;
  bit         rw_seen = 0;
  logic [4:0] model_imm = '0;

  assign act = {fetch_req_o, ir_write_o, imm_op_o, alu_en_o, mem_req_o, mem_we_o,
                reg_write_o, pc_write_o, pc_src_o, trap_o, trap_cause_o};

  function automatic logic rb();
    return 1'($urandom & 1);
  endfunction

  function automatic out_t mk(input logic fr, irw, alu, mr, mw, rw, pw, ps, tr,
                              input logic [1:0] tc);
    out_t o;
    o = {fr, irw, model_imm, alu, mr, mw, rw, pw, ps, tr, tc};
    return o;
  endfunction

  function automatic bit is_legal(input logic [31:0] ins);
    logic [4:0] o;
    o = ins[6:2];
    return (ins[1:0] == 2'b11) && (o inside {5'b01100, 5'b00100, 5'b00000, 5'b01000,
                                            5'b11000, 5'b11011, 5'b11001, 5'b01101, 5'b00101});
  endfunction

  task automatic chk_out(input out_t exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic fv, input logic [31:0] ins, input logic mr, bt, tc,
                      input out_t exp, input string name);
    @(negedge clk);
    fetch_valid_i = fv; instr_i = ins; mem_ready_i = mr; branch_taken_i = bt; trap_clear_i = tc;
    #1;
    cyc++;
    chk_out(exp, name);
    if (act.fetch_req && !ret_seen && cyc > fetch_cyc) begin
      ret_seen = 1; ret_cyc = cyc;
    end
    if (act.reg_write) rw_seen = 1;
  endtask

  task automatic trap_seq(input logic [1:0] cause, input int hold);
    for (int i = 0; i < hold; i++)
      step(rb(), $urandom, rb(), rb(), 1'b0, mk(0,0,0,0,0,0,0,0,1,cause), "trap_hold");
    step(rb(), $urandom, rb(), rb(), 1'b1, mk(0,0,0,0,0,0,0,0,1,cause), "trap_clear");
  endtask

  // Expected behaviour of one instruction, starting with the FSM already in FETCH.
  task automatic run_instr(input logic [31:0] ins, input int fdelay, input logic bt,
                           input int mwait, input int thold);
    logic [4:0] o;
    bit ld, st, br, jmp;
    logic rdy;
    o = ins[6:2];
    ld = (o == 5'b00000); st = (o == 5'b01000); br = (o == 5'b11000);
    jmp = (o == 5'b11011) || (o == 5'b11001);
    for (int i = 0; i < fdelay; i++)
      step(1'b0, $urandom, rb(), rb(), rb(), mk(1,0,0,0,0,0,0,0,0,0), "fetch_wait");
    step(1'b1, ins, rb(), rb(), rb(), mk(1,1,0,0,0,0,0,0,0,0), "fetch");
    fetch_cyc = cyc; ret_seen = 0; rw_seen = 0;
    model_imm = o;
    step(rb(), $urandom, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0), "decode");
    if (!is_legal(ins)) begin
      trap_seq(2'b01, thold);
      return;
    end
    step(rb(), $urandom, rb(), bt, rb(), mk(0,0,1,0,0,0,br,br & bt,0,0), "execute");
    if (br) return;
    if (ld || st) begin
      for (int k = 1; k <= MEM_TIMEOUT; k++) begin
        rdy = (k == mwait + 1);
        step(rb(), $urandom, rdy, rb(), rb(), mk(0,0,0,1,st,0,st & rdy,0,0,0), "memory");
        if (rdy) break;
        if (k == MEM_TIMEOUT) begin
          trap_seq(2'b10, thold);
          return;
        end
      end
      if (st) return;
    end
    step(rb(), $urandom, rb(), rb(), rb(), mk(0,0,0,0,0,1,1,jmp,0,0), "writeback");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[11];
    logic [31:0] pool[12];
    logic [31:0] ins;
    int mw, r;

    tbl[0]  = '{32'h00500093, 1'b0, 0,  4, 5'b00100, 1'b1};
    tbl[1]  = '{32'h00008663, 1'b1, 0,  3, 5'b11000, 1'b0};
    tbl[2]  = '{32'h00008663, 1'b0, 0,  3, 5'b11000, 1'b0};
    tbl[3]  = '{32'h0000a103, 1'b0, 3,  8, 5'b00000, 1'b1};
    tbl[4]  = '{32'h0020a023, 1'b0, 0,  4, 5'b01000, 1'b0};
    tbl[5]  = '{32'h000010b7, 1'b0, 0,  4, 5'b01101, 1'b1};
    tbl[6]  = '{32'h00001097, 1'b0, 0,  4, 5'b00101, 1'b1};
    tbl[7]  = '{32'h0000006f, 1'b0, 0,  4, 5'b11011, 1'b1};
    tbl[8]  = '{32'h00008067, 1'b0, 0,  4, 5'b11001, 1'b1};
    tbl[9]  = '{32'h002081b3, 1'b0, 0,  4, 5'b01100, 1'b1};
    tbl[10] = '{32'h0000a103, 1'b0, 14, 19, 5'b00000, 1'b1};

    pool = '{32'h00500093, 32'h002081b3, 32'h0000a103, 32'h0020a023, 32'h00008663,
             32'h000010b7, 32'h00001097, 32'h0000006f, 32'h00008067, 32'h0000007f,
             32'h00500091, 32'h0000000b};

    // Reset and the single IDLE cycle
    repeat (2) @(negedge clk);
    #1 chk_out(out_t'(0), "reset_state");
    @(negedge clk) rst_n = 1'b1;
    #1 chk_out(out_t'(0), "idle_after_reset");
    for (int i = 0; i < 5; i++)
      step(1'b0, $urandom, rb(), rb(), rb(), mk(1,0,0,0,0,0,0,0,0,0), "fetch_hold");

    foreach (tbl[i]) begin
      run_instr(tbl[i].instr, 0, tbl[i].bt, tbl[i].mwait, 0);
      step(1'b0, $urandom, rb(), rb(), rb(), mk(1,0,0,0,0,0,0,0,0,0), "post_fetch");
      checks++;
      if (!ret_seen || (ret_cyc - fetch_cyc) != tbl[i].lat) begin
        errors++;
        $display("FAIL latency instr=%h got=%0d expected=%0d", tbl[i].instr,
                 ret_seen ? ret_cyc - fetch_cyc : -1, tbl[i].lat);
      end
      checks++;
      if (rw_seen != tbl[i].rw) begin
        errors++;
        $display("FAIL reg_write_seen instr=%h got=%0d expected=%0d", tbl[i].instr, rw_seen, tbl[i].rw);
      end
      checks++;
      if (act.imm_op !== tbl[i].imm) begin
        errors++;
        $display("FAIL imm_op instr=%h got=%b expected=%b", tbl[i].instr, act.imm_op, tbl[i].imm);
      end
      $display("vec %0d instr=%h latency=%0d", i, tbl[i].instr, ret_cyc - fetch_cyc);
    end

    // Illegal opcode trap held for several cycles, then memory timeout trap
    run_instr(32'h0000007f, 1, 1'b0, 0, 4);
    $display("illegal instr=0000007f trapped");
    run_instr(32'h0000a103, 0, 1'b0, 1000, 2);
    $display("timeout instr=0000a103 trapped");
    step(1'b0, $urandom, rb(), rb(), rb(), mk(1,0,0,0,0,0,0,0,0,0), "fetch_after_trap");

    // Asynchronous reset in the middle of a load's MEMORY phase
    step(1'b1, 32'h0000a103, 1'b0, 1'b0, 1'b0, mk(1,1,0,0,0,0,0,0,0,0), "rst_fetch");
    model_imm = 5'b00000;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0), "rst_decode");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,1,0,0,0,0,0,0,0), "rst_execute");
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, mk(0,0,0,1,0,0,0,0,0,0), "rst_memory");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, mk(0,0,0,1,0,0,0,0,0,0), "rst_memory_ready");
    rw_seen = 0;
    #2 rst_n = 1'b0;
    #1 chk_out(out_t'(0), "async_reset");
    @(posedge clk); #1 chk_out(out_t'(0), "reset_held");
    @(negedge clk) rst_n = 1'b1;
    #1 chk_out(out_t'(0), "idle_after_midreset");
    for (int i = 0; i < 4; i++)
      step(1'b0, $urandom, 1'b1, rb(), rb(), mk(1,0,0,0,0,0,0,0,0,0), "fetch_after_midreset");
    checks++;
    if (rw_seen) begin
      errors++;
      $display("FAIL aborted_reg_write got=1 expected=0");
    end
    $display("midreset load aborted");

    // Random instruction stream
    for (int n = 0; n < 40; n++) begin
      ins = pool[$urandom_range(0, 11)];
      r = $urandom_range(0, 9);
      mw = (r < 6) ? r : (r == 6) ? 14 : (r == 7) ? 13 : 30;
      run_instr(ins, $urandom_range(0, 3), rb(), mw, $urandom_range(0, 3));
      $display("rand %0d instr=%h mwait=%0d", n, ins, mw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It fetches an instruction over a valid handshake and captures opcode[6:2] for the immediate generator's select input. It then steps the datapath through DECODE / EXECUTE / MEMORY / WRITEBACK, and traps on illegal opcodes or memory timeout. It sits between the instruction/data memory interfaces and the register file, ALU, immediate generator and PC.

Parameters:
MEM_TIMEOUT, 15, maximum cycles spent in MEMORY waiting for mem_ready before trapping (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr  input  32  instruction word from instruction memory
fetch_valid  input  1  instr valid this cycle
mem_ready  input  1  data memory access complete this cycle
branch_taken  input  1  ALU branch compare result, sampled in EXECUTE
trap_clear  input  1  releases TRAP state
fetch_req  output  1  request instruction (FETCH state)
ir_write  output  1  one-cycle pulse: instruction register load
imm_op  output  5  registered opcode[6:2] to immediate generator select
alu_en  output  1  ALU operation cycle
mem_req  output  1  data memory request
mem_we  output  1  data memory write (store)
reg_write  output  1  register file write enable
pc_write  output  1  PC update pulse
pc_src  output  1  0 = PC+4, 1 = branch/jump target
trap  output  1  trap active
trap_cause  output  2  00 none, 01 illegal instr, 10 memory timeout

Behaviour:
- Reset (async, rst_n low): state IDLE, imm_op = 0, opcode/funct3 registers = 0, timeout counter = 0, trap_cause = 00. All outputs are 0 during reset.
- Outputs are Moore, decoded from the registered state and the registered opcode. No output depends combinationally on instr.
- IDLE: all outputs 0. Goes unconditionally to FETCH on the next edge.
- FETCH: fetch_req = 1. On fetch_valid, capture instr[6:0] into the opcode register, drive ir_write = 1 that same cycle, and go to DECODE. Without fetch_valid, stay in FETCH indefinitely.
- imm_op = captured opcode[6:2]. It holds until the next capture.
- DECODE: checks legality.
  - Legal: opcode[1:0] = 11 and opcode[6:2] is one of 01100, 00100, 00000, 01000, 11000, 11011, 11001, 01101, 00101.
  - Illegal: go to TRAP and set trap_cause = 01. Legal: go to EXECUTE.
- EXECUTE: alu_en = 1.
  - BRANCH (11000): pc_write = 1, pc_src = branch_taken, then go to FETCH.
  - LOAD (00000) / STORE (01000): go to MEMORY and clear the timeout counter.
  - All other legal opcodes: go to WRITEBACK.
- MEMORY: mem_req = 1. mem_we = 1 for a store only. The counter increments each cycle that mem_ready = 0.
  - mem_ready = 1 with a store: pc_write = 1, pc_src = 0, then go to FETCH.
  - mem_ready = 1 with a load: go to WRITEBACK.
  - Counter reaches MEM_TIMEOUT without mem_ready: go to TRAP and set trap_cause = 10.
  - mem_ready wins if it arrives in the same cycle the counter hits the limit.
- WRITEBACK: reg_write = 1 and pc_write = 1. pc_src = 1 for JAL (11011) and JALR (11001), else 0. Then go to FETCH.
- TRAP: trap = 1, and trap_cause holds. On trap_clear, go to FETCH and reset trap_cause to 00. trap_clear is ignored in all other states.
- Minimum latency, counted from the FETCH cycle with fetch_valid asserted:
  - branch: 3 cycles
  - R/I/U/jump: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
  - add 1 cycle per mem_ready wait.
- Reset asserted mid-instruction: immediate return to IDLE. No pc_write or reg_write is issued afterwards for the aborted instruction.
- State encoding is free, but unreachable encodings recover to IDLE.

Test Plan:
- Release reset; hold fetch_valid = 0 for 5 cycles -> IDLE for 1 cycle, then fetch_req = 1 held; all other outputs 0.
- Fetch 0x00500093 (addi) with fetch_valid on the first FETCH cycle -> ir_write pulse, imm_op = 00100. Then DECODE, EXECUTE (alu_en), WRITEBACK (reg_write = 1, pc_write = 1, pc_src = 0); back in FETCH on cycle 4.
- Fetch 0x00008663 (beq) with branch_taken = 1 -> imm_op = 11000; EXECUTE shows pc_write = 1, pc_src = 1; FETCH on cycle 3. Repeat with branch_taken = 0 -> pc_src = 0.
- Fetch 0x0000a103 (lw) with mem_ready delayed 3 cycles -> mem_req = 1 and mem_we = 0 for 4 cycles, then WRITEBACK with reg_write = 1. Then fetch sw 0x0020a023 with mem_ready immediate -> mem_we = 1 for 1 cycle, pc_write = 1, no reg_write.
- Fetch 0x0000007f (opcode 11111) -> TRAP, trap = 1, trap_cause = 01, held until trap_clear pulse, then FETCH with trap_cause = 00. Load with mem_ready never asserted -> after 15 MEMORY cycles, trap_cause = 10.
- Assert rst_n low during MEMORY of a load -> all outputs 0 asynchronously and imm_op = 0; after release, IDLE then FETCH, and no reg_write observed.
